// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter sharing one synchronous single-port memory between an
// instruction-fetch port (read only) and a data port (read/write).
// Each transaction walks IDLE -> ISSUE -> RESP:
//   IDLE  : pick a winner, latch its address/we/wdata
//   ISSUE : m_en strobe for one cycle
//   RESP  : one-cycle ack to the owner; m_rdata is passed straight through
// Ports:
//   clk, reset (async, active-low)
//   i_req/i_addr -> i_rdata/i_ack          instruction-fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack   data requester
//   m_en/m_we/m_addr/m_wdata, m_rdata      memory side (read data one cycle after m_en)
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Owner encoding: 0 = instruction port, 1 = data port.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_owner_q, last_owner_d;
  logic                    m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
  logic                    winner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      // Data counts as last served so the first tie after reset goes to fetch.
      last_owner_q <= OWN_D;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;

    // On a tie the port that was not served last wins.
    if (i_req && d_req) begin
      winner = ~last_owner_q;
    end else if (i_req) begin
      winner = OWN_I;
    end else begin
      winner = OWN_D;
    end

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d      = winner;
          last_owner_d = winner;
          state_d      = ISSUE;
          if (winner == OWN_I) begin
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
          end else begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All strobes are decodes of registered state; no input feeds them.
  assign m_en    = (state_q == ISSUE);
  assign i_ack   = (state_q == RESP) && (owner_q == OWN_I);
  assign d_ack   = (state_q == RESP) && (owner_q == OWN_D);
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one synchronous single-port memory between the instruction-fetch port and the data port of the core, replacing separate instruction and data memories behind the mother board. Grants are round-robin. Each granted request is latched, issued to memory for one cycle and completed with a one-cycle acknowledge pulse. A fixed three-state FSM (IDLE, ISSUE, RESP) sequences every transaction.

## Interface
- ADDR_WIDTH, 32, address width of requesters and memory
- DATA_WIDTH, 32, data width of requesters and memory

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- i_req  in  1  instruction-fetch request (read only)
- i_addr  in  ADDR_WIDTH  fetch address
- i_rdata  out  DATA_WIDTH  fetch data, valid only while i_ack=1
- i_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request
- d_we  in  1  data write enable (1 = write, 0 = read)
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  data write value
- d_rdata  out  DATA_WIDTH  data read value, valid only while d_ack=1
- d_ack  out  1  one-cycle completion pulse for data
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable, only meaningful with m_en
- m_addr  out  ADDR_WIDTH  memory address
- m_wdata  out  DATA_WIDTH  memory write data
- m_rdata  in  DATA_WIDTH  memory read data, valid the cycle after m_en=1

## Operation
- Registered state: fsm (IDLE/ISSUE/RESP), owner (0=instr, 1=data), last_owner, m_we, m_addr, m_wdata.
- IDLE: if no request, stay. If exactly one request, grant it. If both, grant the one not equal to last_owner. On grant: owner and last_owner take the winner; m_addr, m_we and m_wdata latch the winner's inputs; fsm goes to ISSUE.
- Instruction grant latches m_we=0 and m_wdata=0.
- ISSUE: m_en=1 (combinational from state). fsm goes to RESP unconditionally.
- RESP: m_en=0. Ack of owner = 1 for this cycle only. fsm goes to IDLE.
- Requests are not sampled in RESP. A req still high in the IDLE cycle after ack is a new request.
- i_rdata = d_rdata = m_rdata (combinational pass-through). Content is defined only during the owner's RESP cycle for reads. Data writes ack with undefined d_rdata.
- Requester contract: req and its addr/we/wdata are held until ack. Arbiter latches at grant, so later changes do not affect the transaction in flight.
- Dropping req after grant does not abort. The memory access still occurs and ack still pulses.
- Non-owner req is ignored until the fsm returns to IDLE.
- reset=0 (any time, including mid-ISSUE or RESP):
  - fsm=IDLE; m_en, m_we, i_ack, d_ack = 0; m_addr, m_wdata = 0.
  - last_owner = data, so the first simultaneous request after reset goes to instruction.
  - An interrupted transaction is dropped with no ack.

## Timing
- Request first seen high in IDLE at edge t → m_en high in cycle t+1 → ack in cycle t+2 → IDLE in cycle t+3.
- Fixed latency: 2 cycles req→ack. Throughput: one transaction per 3 cycles.
- Continuous dual requests alternate owners: I, D, I, D… Each requester is guaranteed service within 6 cycles of asserting req.
- Only one of i_ack and d_ack is ever high in a cycle. m_en is never high in two consecutive cycles.
- All outputs are glitch-free registered decodes of fsm/owner, except rdata pass-through.

## Test plan
- Reset then single fetch:
  - Stimulus: release reset, i_req=1, i_addr=0x10, memory[0x10]=0xDEADBEEF.
  - Required: m_en=1 with m_addr=0x10 and m_we=0 one cycle after; i_ack=1 with i_rdata=0xDEADBEEF at +2; d_ack stays 0.
- Data write then read:
  - Stimulus: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 until ack; then read 0x40.
  - Required: write has m_we=1, m_wdata=0x12345678; read acks with d_rdata=0x12345678.
- Simultaneous requests after reset, both held high for 12 cycles.
  - Required: ack order i, d, i, d, each 3 cycles apart; never both acks in one cycle.
- Request dropped mid-transaction:
  - Stimulus: d_req high one cycle (granted), then low.
  - Required: m_en still pulses; d_ack still pulses at +2.
- Reset mid-operation:
  - Stimulus: assert reset=0 during ISSUE.
  - Required: m_en=0 immediately (asynchronous); no ack; after release with i_req=d_req=1, instruction is granted first.
- Input change after grant:
  - Stimulus: change i_addr from 0x10 to 0x20 during ISSUE.
  - Required: m_addr stays 0x10 and returned data is memory[0x10].
